// File: rtl/mem_access.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_access : memory stage, single-outstanding req/gnt/rvalid data-bus access
// Revision   : 1.0
// ---------------------------------------------------------------------------
module mem_access #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        lb_exe,
  input  logic        lh_exe,
  input  logic        lbu_exe,
  input  logic        lhu_exe,
  input  logic        lw_exe,
  input  logic        sb_exe,
  input  logic        sh_exe,
  input  logic        sw_exe,
  input  logic [31:0] mem_addr_exe,
  input  logic [31:0] reg_rdata2_exe,
  input  logic        reg_wen_exe,
  input  logic [4:0]  reg_waddr_exe,
  input  logic [31:0] reg_wdata_exe,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata,
  output logic        hold_req_mem,
  output logic        reg_wen_mem,
  output logic [4:0]  reg_waddr_mem,
  output logic [31:0] reg_wdata_mem,
  output logic        bus_err_mem
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT_R = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] tmo_cnt;

  logic        is_load, is_store, mem_op;
  logic        waiting, complete, abort, load_done;
  logic [1:0]  lane;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  assign is_load  = lb_exe | lh_exe | lbu_exe | lhu_exe | lw_exe;
  assign is_store = sb_exe | sh_exe | sw_exe;
  assign mem_op   = is_load | is_store;
  assign lane     = mem_addr_exe[1:0];

  assign waiting   = ((state == IDLE) & mem_op & ~dbus_gnt) | ((state == WAIT_R) & ~dbus_rvalid);
  assign load_done = (state == WAIT_R) & dbus_rvalid;
  assign complete  = ((state == IDLE) & mem_op & is_store & dbus_gnt) | load_done;
  assign abort     = (TIMEOUT != 0) & waiting & (tmo_cnt == TO_VAL);

  // Reset gates the combinational handshakes so nothing leaks out while held in reset.
  assign dbus_req     = rst_b & (state == IDLE) & mem_op & ~abort;
  assign hold_req_mem = rst_b & mem_op & ~complete & ~abort;
  assign dbus_we      = is_store;
  assign dbus_addr    = {mem_addr_exe[31:2], 2'b00};

  always_comb begin
    dbus_be    = 4'b0000;
    dbus_wdata = reg_rdata2_exe;
    if (sb_exe) begin
      dbus_be    = 4'b0001 << lane;
      dbus_wdata = {4{reg_rdata2_exe[7:0]}};
    end else if (sh_exe) begin
      dbus_be    = lane[1] ? 4'b1100 : 4'b0011;
      dbus_wdata = {2{reg_rdata2_exe[15:0]}};
    end else if (sw_exe) begin
      dbus_be    = 4'b1111;
    end
  end

  always_comb begin
    case (lane)
      2'd0:    byte_sel = dbus_rdata[7:0];
      2'd1:    byte_sel = dbus_rdata[15:8];
      2'd2:    byte_sel = dbus_rdata[23:16];
      default: byte_sel = dbus_rdata[31:24];
    endcase
    half_sel = lane[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
    if (lb_exe)       load_data = {{24{byte_sel[7]}}, byte_sel};
    else if (lbu_exe) load_data = {24'd0, byte_sel};
    else if (lh_exe)  load_data = {{16{half_sel[15]}}, half_sel};
    else if (lhu_exe) load_data = {16'd0, half_sel};
    else              load_data = dbus_rdata;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mem_op & is_load & dbus_gnt) state_nxt = WAIT_R;
      WAIT_R:  if (dbus_rvalid | abort)         state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state   <= IDLE;
      tmo_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (complete | abort) tmo_cnt <= '0;
      else if (waiting)     tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      reg_wen_mem   <= 1'b0;
      reg_waddr_mem <= 5'd0;
      reg_wdata_mem <= 32'd0;
      bus_err_mem   <= 1'b0;
    end else begin
      reg_wdata_mem <= load_done ? load_data : reg_wdata_exe;
      if (abort) begin
        reg_wen_mem   <= 1'b0;
        reg_waddr_mem <= reg_waddr_exe;
        bus_err_mem   <= 1'b1;
      end else if (hold_req_mem) begin
        reg_wen_mem   <= 1'b0;
        bus_err_mem   <= 1'b0;
      end else begin
        reg_wen_mem   <= reg_wen_exe;
        reg_waddr_mem <= reg_waddr_exe;
        bus_err_mem   <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_access : directed stimulus with a queue-based write-back scoreboard
// Revision      : 1.0
// ---------------------------------------------------------------------------
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        lb_exe, lh_exe, lbu_exe, lhu_exe, lw_exe, sb_exe, sh_exe, sw_exe;
  logic [31:0] mem_addr_exe, reg_rdata2_exe, reg_wdata_exe;
  logic        reg_wen_exe;
  logic [4:0]  reg_waddr_exe;
  logic        dbus_req, dbus_we, dbus_gnt, dbus_rvalid;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_be;
  logic        hold_req_mem, reg_wen_mem, bus_err_mem;
  logic [4:0]  reg_waddr_mem;
  logic [31:0] reg_wdata_mem;

  typedef struct packed {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        err;
  } wb_t;

  wb_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;

  mem_access #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_b(rst_b),
    .lb_exe(lb_exe), .lh_exe(lh_exe), .lbu_exe(lbu_exe), .lhu_exe(lhu_exe), .lw_exe(lw_exe),
    .sb_exe(sb_exe), .sh_exe(sh_exe), .sw_exe(sw_exe),
    .mem_addr_exe(mem_addr_exe), .reg_rdata2_exe(reg_rdata2_exe),
    .reg_wen_exe(reg_wen_exe), .reg_waddr_exe(reg_waddr_exe), .reg_wdata_exe(reg_wdata_exe),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
    .dbus_wdata(dbus_wdata), .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
    .hold_req_mem(hold_req_mem), .reg_wen_mem(reg_wen_mem), .reg_waddr_mem(reg_waddr_mem),
    .reg_wdata_mem(reg_wdata_mem), .bus_err_mem(bus_err_mem)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every write-back or bus-error presentation must match the head of the queue.
  always @(negedge clk) begin
    if (rst_b && (reg_wen_mem || bus_err_mem)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got wen=%0b waddr=%0d wdata=0x%08h err=%0b with empty queue",
                 reg_wen_mem, reg_waddr_mem, reg_wdata_mem, bus_err_mem);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        if (reg_wen_mem !== e.wen || reg_waddr_mem !== e.waddr ||
            reg_wdata_mem !== e.wdata || bus_err_mem !== e.err) begin
          errors++;
          $display("FAIL wb_result: got wen=%0b waddr=%0d wdata=0x%08h err=%0b expected wen=%0b waddr=%0d wdata=0x%08h err=%0b",
                   reg_wen_mem, reg_waddr_mem, reg_wdata_mem, bus_err_mem,
                   e.wen, e.waddr, e.wdata, e.err);
        end
      end
    end
  end

  task automatic clear_ops();
    {lb_exe, lh_exe, lbu_exe, lhu_exe, lw_exe, sb_exe, sh_exe, sw_exe} = 8'd0;
    reg_wen_exe = 1'b0;
    dbus_gnt    = 1'b0;
    dbus_rvalid = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // kind: 0 lb, 1 lh, 2 lbu, 3 lhu, 4 lw
  task automatic do_load(input int kind, input logic [31:0] addr, input logic [31:0] rdata,
                         input logic [4:0] waddr, input int gnt_delay, input logic [31:0] exp_data);
    lb_exe = (kind == 0); lh_exe = (kind == 1); lbu_exe = (kind == 2);
    lhu_exe = (kind == 3); lw_exe = (kind == 4);
    mem_addr_exe = addr; reg_wen_exe = 1'b1; reg_waddr_exe = waddr; reg_wdata_exe = 32'hDEAD0000;
    for (int i = 0; i <= gnt_delay; i++) begin
      dbus_gnt = (i == gnt_delay);
      @(negedge clk);
      chk("ld_req", {31'd0, dbus_req}, 32'd1);
      chk("ld_addr", dbus_addr, {addr[31:2], 2'b00});
      chk("ld_hold_wait", {31'd0, hold_req_mem}, 32'd1);
      next_cycle();
    end
    chk("ld_be", {28'd0, dbus_be}, 32'd0);
    dbus_gnt = 1'b0; dbus_rvalid = 1'b1; dbus_rdata = rdata;
    exp_q.push_back('{wen: 1'b1, waddr: waddr, wdata: exp_data, err: 1'b0});
    @(negedge clk);
    chk("ld_req_wait_r", {31'd0, dbus_req}, 32'd0);
    chk("ld_hold_done", {31'd0, hold_req_mem}, 32'd0);
    next_cycle();
    clear_ops();
  endtask

  // kind: 0 sb, 1 sh, 2 sw
  task automatic do_store(input int kind, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    sb_exe = (kind == 0); sh_exe = (kind == 1); sw_exe = (kind == 2);
    mem_addr_exe = addr; reg_rdata2_exe = data; reg_wen_exe = 1'b0; dbus_gnt = 1'b1;
    @(negedge clk);
    chk("st_req", {31'd0, dbus_req}, 32'd1);
    chk("st_we", {31'd0, dbus_we}, 32'd1);
    chk("st_addr", dbus_addr, {addr[31:2], 2'b00});
    chk("st_be", {28'd0, dbus_be}, {28'd0, exp_be});
    chk("st_wdata", dbus_wdata, exp_wdata);
    chk("st_hold", {31'd0, hold_req_mem}, 32'd0);
    next_cycle();
    clear_ops();
    @(negedge clk);
    chk("st_wen_mem", {31'd0, reg_wen_mem}, 32'd0);
    next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_b = 1'b0;
    clear_ops();
    mem_addr_exe = 32'd0; reg_rdata2_exe = 32'd0; reg_wdata_exe = 32'd0;
    reg_waddr_exe = 5'd0; dbus_rdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wen", {31'd0, reg_wen_mem}, 32'd0);
    chk("rst_waddr", {27'd0, reg_waddr_mem}, 32'd0);
    chk("rst_wdata", reg_wdata_mem, 32'd0);
    chk("rst_err", {31'd0, bus_err_mem}, 32'd0);
    chk("rst_req", {31'd0, dbus_req}, 32'd0);
    next_cycle();
    rst_b = 1'b1;
    next_cycle();

    // Non-memory passthrough
    reg_wen_exe = 1'b1; reg_waddr_exe = 5'd5; reg_wdata_exe = 32'h0000_1234;
    exp_q.push_back('{wen: 1'b1, waddr: 5'd5, wdata: 32'h0000_1234, err: 1'b0});
    @(negedge clk);
    chk("pt_req", {31'd0, dbus_req}, 32'd0);
    chk("pt_hold", {31'd0, hold_req_mem}, 32'd0);
    next_cycle();
    clear_ops();

    do_load(0, 32'h0000_0103, 32'h80FF_0000, 5'd7, 0, 32'hFFFF_FF80);
    do_load(3, 32'h0000_0202, 32'hBEEF_1234, 5'd9, 3, 32'h0000_BEEF);
    do_load(1, 32'h0000_0000, 32'h1234_8001, 5'd10, 0, 32'hFFFF_8001);
    do_load(2, 32'h0000_0001, 32'h0000_9A00, 5'd11, 1, 32'h0000_009A);
    do_load(4, 32'h0000_0008, 32'hCAFE_BABE, 5'd12, 0, 32'hCAFE_BABE);

    do_store(0, 32'h0000_0301, 32'hAABB_CCDD, 4'b0010, 32'hDDDD_DDDD);
    do_store(1, 32'h0000_0302, 32'h0000_A1B2, 4'b1100, 32'hA1B2_A1B2);

    // Timeout: gnt at once, rvalid never arrives
    lw_exe = 1'b1; mem_addr_exe = 32'h0000_0400; reg_wen_exe = 1'b1;
    reg_waddr_exe = 5'd3; reg_wdata_exe = 32'd0; dbus_gnt = 1'b1;
    @(negedge clk);
    chk("to_req", {31'd0, dbus_req}, 32'd1);
    next_cycle();
    dbus_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("to_hold_wait", {31'd0, hold_req_mem}, 32'd1);
      next_cycle();
    end
    @(negedge clk);
    chk("to_abort_hold", {31'd0, hold_req_mem}, 32'd0);
    chk("to_abort_req", {31'd0, dbus_req}, 32'd0);
    exp_q.push_back('{wen: 1'b0, waddr: 5'd3, wdata: 32'd0, err: 1'b1});
    next_cycle();
    clear_ops();
    // Late rvalid in IDLE must not replace the passthrough result
    reg_wen_exe = 1'b1; reg_waddr_exe = 5'd4; reg_wdata_exe = 32'h0000_0077;
    dbus_rvalid = 1'b1; dbus_rdata = 32'hFFFF_FFFF;
    exp_q.push_back('{wen: 1'b1, waddr: 5'd4, wdata: 32'h0000_0077, err: 1'b0});
    @(negedge clk);
    chk("late_rv_hold", {31'd0, hold_req_mem}, 32'd0);
    next_cycle();
    clear_ops();
    @(negedge clk);
    chk("err_single_pulse", {31'd0, bus_err_mem}, 32'd0);
    next_cycle();

    // Reset while in WAIT_R
    lw_exe = 1'b1; mem_addr_exe = 32'h0000_0500; reg_wen_exe = 1'b1;
    reg_waddr_exe = 5'd6; reg_wdata_exe = 32'h0000_CAFE; dbus_gnt = 1'b1;
    next_cycle();
    dbus_gnt = 1'b0;
    #2 rst_b = 1'b0;
    #1;
    chk("mid_rst_req", {31'd0, dbus_req}, 32'd0);
    chk("mid_rst_hold", {31'd0, hold_req_mem}, 32'd0);
    chk("mid_rst_wen", {31'd0, reg_wen_mem}, 32'd0);
    chk("mid_rst_waddr", {27'd0, reg_waddr_mem}, 32'd0);
    chk("mid_rst_wdata", reg_wdata_mem, 32'd0);
    chk("mid_rst_err", {31'd0, bus_err_mem}, 32'd0);
    next_cycle();
    clear_ops();
    dbus_rvalid = 1'b1;
    next_cycle();
    rst_b = 1'b1;
    next_cycle();
    dbus_rvalid = 1'b0;
    do_store(2, 32'h0000_0600, 32'h1122_3344, 4'b1111, 32'h1122_3344);

    repeat (3) next_cycle();
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
